// File: rtl/da_pkg.sv
// Shared definitions for the DA core and its coefficient table loader.
package da_pkg;

  localparam int unsigned COEF_W        = 16;
  localparam int unsigned CIN_W         = 19;
  localparam int unsigned CADDR_W       = 11;
  localparam int unsigned N_TAPS        = 64;
  localparam int unsigned N_BANKS       = 8;
  localparam int unsigned TAPS_PER_BANK = 8;
  localparam int unsigned PAIR_W        = COEF_W + 1;
  localparam int unsigned N_PAIRS       = TAPS_PER_BANK / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Valid/address sideband that travels alongside the sum pipeline.
  typedef struct packed {
    logic               valid;
    logic [CADDR_W-1:0] addr;
  } sideband_t;

endpackage

// File: rtl/da_subset_sum.sv
// Three-stage subset-sum pipeline: masked coefficients, pair sums, final sum.
// Data registers hold their value whenever the matching valid bit is low.
module da_subset_sum
  import da_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  in_valid,
  input  logic [CADDR_W-1:0]                    in_addr,
  input  logic [TAPS_PER_BANK-1:0][COEF_W-1:0]  coefs,
  input  logic [TAPS_PER_BANK-1:0]              mask,
  output logic [CIN_W-1:0]                      sum,
  output logic [CADDR_W-1:0]                    addr,
  output logic                                  valid
);

  logic [TAPS_PER_BANK-1:0][COEF_W-1:0] s1_coef_q, s1_coef_d;
  logic [N_PAIRS-1:0][PAIR_W-1:0]       s2_pair_q, s2_pair_d;
  logic [CIN_W-1:0]                     s3_sum_q, s3_sum_d;
  sideband_t                            s1_sb_q, s1_sb_d;
  sideband_t                            s2_sb_q, s2_sb_d;
  sideband_t                            s3_sb_q, s3_sb_d;

  always_comb begin
    s1_coef_d = s1_coef_q;
    s1_sb_d   = '{valid: in_valid, addr: s1_sb_q.addr};
    if (in_valid) begin
      s1_sb_d.addr = in_addr;
      for (int k = 0; k < TAPS_PER_BANK; k++) begin
        s1_coef_d[k] = mask[k] ? coefs[k] : '0;
      end
    end

    s2_pair_d = s2_pair_q;
    s2_sb_d   = '{valid: s1_sb_q.valid, addr: s2_sb_q.addr};
    if (s1_sb_q.valid) begin
      s2_sb_d.addr = s1_sb_q.addr;
      for (int j = 0; j < N_PAIRS; j++) begin
        s2_pair_d[j] = {s1_coef_q[2*j][COEF_W-1],   s1_coef_q[2*j]}
                     + {s1_coef_q[2*j+1][COEF_W-1], s1_coef_q[2*j+1]};
      end
    end

    s3_sum_d = s3_sum_q;
    s3_sb_d  = '{valid: s2_sb_q.valid, addr: s3_sb_q.addr};
    if (s2_sb_q.valid) begin
      s3_sb_d.addr = s2_sb_q.addr;
      s3_sum_d     = '0;
      for (int j = 0; j < N_PAIRS; j++) begin
        s3_sum_d = s3_sum_d
                 + {{(CIN_W-PAIR_W){s2_pair_q[j][PAIR_W-1]}}, s2_pair_q[j]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_coef_q <= '0;
      s2_pair_q <= '0;
      s3_sum_q  <= '0;
      s1_sb_q   <= '0;
      s2_sb_q   <= '0;
      s3_sb_q   <= '0;
    end else begin
      s1_coef_q <= s1_coef_d;
      s2_pair_q <= s2_pair_d;
      s3_sum_q  <= s3_sum_d;
      s1_sb_q   <= s1_sb_d;
      s2_sb_q   <= s2_sb_d;
      s3_sb_q   <= s3_sb_d;
    end
  end

  assign sum   = s3_sum_q;
  assign addr  = s3_sb_q.addr;
  assign valid = s3_sb_q.valid;

endmodule

// File: rtl/da_table_loader.sv
// Builds the DA partial-sum tables from a host-written coefficient file and
// streams them, one entry per clock, into the DA core's coefficient load port.
module da_table_loader #(
  parameter int unsigned COEF_W        = 16,
  parameter int unsigned N_BANKS       = 8,
  parameter int unsigned TAPS_PER_BANK = 8
) (
  input  logic                                        clk,
  input  logic                                        resetn,
  input  logic                                        coef_we,
  input  logic [$clog2(N_BANKS*TAPS_PER_BANK)-1:0]    coef_idx,
  input  logic [COEF_W-1:0]                           coef_data,
  input  logic                                        load_start,
  output logic [COEF_W+$clog2(TAPS_PER_BANK)-1:0]     CIN,
  output logic [$clog2(N_BANKS)+TAPS_PER_BANK-1:0]    CADDR,
  output logic                                        CLOAD,
  output logic                                        busy,
  output logic                                        load_done,
  output logic                                        coef_err
);

  localparam int unsigned N_TAPS = N_BANKS * TAPS_PER_BANK;
  localparam int unsigned BANK_W = $clog2(N_BANKS);
  localparam int unsigned TAP_W  = $clog2(TAPS_PER_BANK);
  localparam int unsigned ADDR_W = BANK_W + TAPS_PER_BANK;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  da_pkg::state_e    state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [COEF_W-1:0] coef_q [N_TAPS];
  logic [COEF_W-1:0] coef_d [N_TAPS];
  da_pkg::sideband_t s0_q, s0_d;
  logic              busy_q, busy_d;
  logic              load_done_q, load_done_d;
  logic              coef_err_q, coef_err_d;

  logic [TAPS_PER_BANK-1:0][COEF_W-1:0] bank_coefs;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= da_pkg::IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The drain ends once the last entry has left the pipeline.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      da_pkg::IDLE:  if (load_start)                state_d = da_pkg::FILL;
      da_pkg::FILL:  if (cnt_q == LAST_ADDR)        state_d = da_pkg::DRAIN;
      da_pkg::DRAIN: if (CLOAD && CADDR == LAST_ADDR) state_d = da_pkg::DONE;
      da_pkg::DONE:                                 state_d = da_pkg::IDLE;
      default:                                      state_d = da_pkg::IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    s0_d        = '{valid: 1'b0, addr: s0_q.addr};
    coef_d      = coef_q;
    coef_err_d  = coef_err_q | (coef_we & busy_q);
    busy_d      = (state_d == da_pkg::FILL) || (state_d == da_pkg::DRAIN);
    load_done_d = (state_d == da_pkg::DONE);

    if (coef_we && !busy_q) begin
      coef_d[coef_idx] = coef_data;
    end

    if (state_q == da_pkg::IDLE && load_start) begin
      cnt_d = '0;
    end else if (state_q == da_pkg::FILL) begin
      s0_d = '{valid: 1'b1, addr: cnt_q};
      if (cnt_q != LAST_ADDR) begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end
  end

  // Bank select picks the eight coefficients feeding the issued entry.
  always_comb begin
    bank_coefs = '0;
    for (int k = 0; k < TAPS_PER_BANK; k++) begin
      bank_coefs[k] = coef_q[{s0_q.addr[ADDR_W-1 -: BANK_W], TAP_W'(k)}];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q       <= '0;
      s0_q        <= '0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      coef_err_q  <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
        coef_q[i] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      s0_q        <= s0_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      coef_err_q  <= coef_err_d;
      coef_q      <= coef_d;
    end
  end

  da_subset_sum u_subset_sum (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (s0_q.valid),
    .in_addr  (s0_q.addr),
    .coefs    (bank_coefs),
    .mask     (s0_q.addr[TAPS_PER_BANK-1:0]),
    .sum      (CIN),
    .addr     (CADDR),
    .valid    (CLOAD)
  );

  assign busy      = busy_q;
  assign load_done = load_done_q;
  assign coef_err  = coef_err_q;

endmodule

// File: doc/da_table_loader.md
# da_table_loader

- Generates and writes the distributed-arithmetic partial-sum tables into the DA core's coefficient SRAM; it is the writer for the core's coefficient load port (CIN/CADDR/CLOAD).
- Holds 64 signed filter coefficients written by the host. On `load_start` it streams all 8 banks × 256 entries, one entry per clock.
- Each entry is the sum of the coefficients selected by the address bits.
- Sits between host configuration logic and the `da` core, whose load port it drives directly.

## Interface
Parameters:
- COEF_W, 16, coefficient width (signed two's complement)
- N_BANKS, 8, SRAM banks (one per DA address byte)
- TAPS_PER_BANK, 8, taps per bank (address bits per bank)

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- coef_we  in  1  coefficient write strobe
- coef_idx  in  6  tap index 0..63
- coef_data  in  16  signed coefficient
- load_start  in  1  one-cycle request to (re)build all tables
- CIN  out  19  table entry data
- CADDR  out  11  {bank[2:0], entry[7:0]}
- CLOAD  out  1  entry valid / write strobe to DA core
- busy  out  1  table build in progress
- load_done  out  1  one-cycle pulse when the last entry has been written
- coef_err  out  1  sticky; a coefficient write was attempted while busy

## Operation
- Coefficient file: 64 × 16 registers, reset to 0.
  - Write when `coef_we` && !busy.
  - `coef_we` while busy is dropped and sets `coef_err`, which clears only on reset.
- Mapping: entry a of bank b = Σ over k=0..7 of (a[k] ? coef[8b+k] : 0).
  - Sign-extended 16→19 bits.
  - Range −262144..262136, so no overflow is possible.
  - Entry 0 of every bank is 0.
- FSM, all states enter on resetn low:
  - IDLE: on `load_start` → FILL, clear address counter.
  - FILL: issue counter value 0..2047 into the pipeline, one per cycle. After issuing 2047 → DRAIN.
  - DRAIN: wait until the pipeline empties (3 cycles) → DONE.
  - DONE: assert `load_done` for one cycle → IDLE.
- `load_start` outside IDLE is ignored.
- `load_start` in the same cycle as `coef_we` in IDLE: the write is accepted and is used by the build.
- Bank select is counter[10:8]; it muxes the 8 coefficients of that bank.
- Counter wraps from 2047 to 0 only via a new `load_start`; it never free-runs.
- Reset mid-build: aborts immediately.
  - The next cycle shows CLOAD=0, busy=0, load_done=0.
  - The coefficient file is also cleared.

## Timing
- Reset values: CIN=0, CADDR=0, CLOAD=0, busy=0, load_done=0, coef_err=0.
- Issue slot: pipeline stage 0 is the counter, valid while the FSM is in FILL.
- Pipeline stages:
  - S1: registered masked coefficients (8 × 16).
  - S2: registered 4 pair sums (17 bits).
  - S3: registered final sum (19 bits) into CIN, with CADDR and CLOAD.
- Cycle 0 is the edge that samples `load_start`:
  - busy rises after cycle 0.
  - First CLOAD=1 (CADDR=0) appears 4 cycles after cycle 0, i.e. 3 cycles after the FILL issue slot for address 0.
- CLOAD stays high for exactly 2048 consecutive cycles. CADDR increments by 1 each cycle, 0x000..0x7FF, and stays held at 0x7FF after the burst.
- `load_done` pulses the cycle after the last CLOAD. busy falls together with `load_done`.
- CIN and CADDR are only meaningful while CLOAD=1. When CLOAD=0 they hold their last values.
- No backpressure: the DA core must accept one entry per clock while CLOAD=1.

## Structure
- Shared package `da_pkg`: COEF_W, CIN_W=19, CADDR_W=11, N_TAPS=64, N_BANKS, TAPS_PER_BANK, and the FSM state enum (IDLE, FILL, DRAIN, DONE). `da` and this block both use these.
- One sub-module, `da_subset_sum`: inputs are the 8 coefficients and an 8-bit mask; output is the 19-bit sum. It implements stages S1–S3 and carries a valid/address sideband.
- The FSM, counter, and coefficient file live in the top of this block.

## Test plan
- All coef=1, load → entry a of every bank = popcount(a) (CADDR 0x0FF → CIN 8; CADDR 0x355 → CIN 4). 2048 CLOAD cycles; `load_done` on the following cycle.
- coef[k]=k+1 → CADDR 0x301 → CIN 25, CADDR 0x380 → CIN 32, CADDR 0x7FF → CIN 484 (sum 57..64).
- All coef=−32768 → CADDR 0x0FF → CIN 19'h40000 (−262144); all coef=32767 → CIN 262136; entry 0 = 0.
- `load_start` at cycle 0 → busy=1 from cycle 1, first CLOAD at cycle 4 with CADDR=0. A second `load_start` mid-build and `coef_we` mid-build → ignored; coef_err=1; tables unchanged.
- resetn low at entry 1000 → next cycle CLOAD=0, busy=0. After reset a rebuild yields all-zero CIN.
- Single coefficient coef[20]=−5, others 0 → bank 2 entries with bit 4 set = −5, all other entries 0 across all banks.
